// File: rtl/relu_pkg.sv
// rtl/relu_pkg.sv - shared state encoding and default widths for the ReLU memory engine
package relu_pkg;

    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_ADDR_WIDTH    = 8;
    localparam int DEF_DATABUS_WIDTH = 32;
    localparam int DEF_HEIGHT        = 2;
    localparam int DEF_WIDTH         = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_WAIT = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4
    } relu_state_e;

endpackage

// File: rtl/relu_unit.sv
// rtl/relu_unit.sv - combinational signed clamp-at-zero, zero-extended to the bus width
module relu_unit #(
    parameter int DATA_WIDTH    = 8,
    parameter int DATABUS_WIDTH = 32
) (
    input  logic signed [DATA_WIDTH-1:0]    x,
    output logic        [DATABUS_WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        if (!x[DATA_WIDTH-1]) begin
            y[DATA_WIDTH-1:0] = x;
        end
    end

endmodule

// File: rtl/relu_with_mem.sv
// rtl/relu_with_mem.sv - in-memory ReLU over N elements on a shared bus; RELU_NEG_COUNT_EN adds neg_count
module relu_with_mem
    import relu_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int DATABUS_WIDTH = DEF_DATABUS_WIDTH,
    parameter int HEIGHT        = DEF_HEIGHT,
    parameter int WIDTH         = DEF_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     done,
    input  logic [ADDR_WIDTH-1:0]    input_addr,
    input  logic [ADDR_WIDTH-1:0]    output_addr,
    output logic                     mem_w,
    output logic                     mem_sel,
    inout  wire  [ADDR_WIDTH-1:0]    address_bus,
    inout  wire  [DATABUS_WIDTH-1:0] data_bus
`ifdef RELU_NEG_COUNT_EN
    ,
    output logic [ADDR_WIDTH-1:0]    neg_count
`endif
);

    localparam int                    N        = HEIGHT * WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);

    relu_state_e                   state_q;
    relu_state_e                   state_d;
    logic [ADDR_WIDTH-1:0]         i_q;
    logic [ADDR_WIDTH-1:0]         in_base_q;
    logic [ADDR_WIDTH-1:0]         out_base_q;
    logic signed [DATA_WIDTH-1:0]  x_q;
    logic [DATABUS_WIDTH-1:0]      y_word;
    logic [ADDR_WIDTH-1:0]         addr_drv;
    logic                          data_oe;
    logic                          launch;

    // The block never consumes the address bus or the upper data bits as inputs.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{address_bus, data_bus};

    assign launch = ((state_q == IDLE) || (state_q == DONE)) && start;

    relu_unit #(
        .DATA_WIDTH    (DATA_WIDTH),
        .DATABUS_WIDTH (DATABUS_WIDTH)
    ) u_relu (
        .x (x_q),
        .y (y_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            i_q        <= '0;
            in_base_q  <= '0;
            out_base_q <= '0;
            x_q        <= '0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                in_base_q  <= input_addr;
                out_base_q <= output_addr;
                i_q        <= '0;
            end
            // Sampling at the end of RD_WAIT covers both combinational and 1-cycle memories.
            if (state_q == RD_WAIT) begin
                x_q <= data_bus[DATA_WIDTH-1:0];
            end
            if ((state_q == WR) && (i_q != LAST_IDX)) begin
                i_q <= i_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        mem_sel  = 1'b0;
        mem_w    = 1'b0;
        data_oe  = 1'b0;
        addr_drv = in_base_q + i_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RD_ADDR;
                end
            end
            RD_ADDR: begin
                mem_sel = 1'b1;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                mem_sel = 1'b1;
                state_d = WR;
            end
            WR: begin
                mem_sel  = 1'b1;
                mem_w    = 1'b1;
                data_oe  = 1'b1;
                addr_drv = out_base_q + i_q;
                state_d  = (i_q == LAST_IDX) ? DONE : RD_ADDR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign done        = (state_q == DONE);
    assign address_bus = mem_sel ? addr_drv : {ADDR_WIDTH{1'bz}};
    assign data_bus    = data_oe ? y_word : {DATABUS_WIDTH{1'bz}};

`ifdef RELU_NEG_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst || launch) begin
            neg_count <= '0;
        end else if ((state_q == WR) && x_q[DATA_WIDTH-1]) begin
            neg_count <= neg_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_relu_with_mem.sv
// tb/tb_relu_with_mem.sv - scoreboard bench for relu_with_mem with a combinational memory model
module tb_relu_with_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        done;
    logic [7:0]  input_addr;
    logic [7:0]  output_addr;
    logic        mem_w;
    logic        mem_sel;
    wire  [7:0]  address_bus;
    wire  [31:0] data_bus;
`ifdef RELU_NEG_COUNT_EN
    logic [7:0]  neg_count;
`endif

    logic        tb_bus_en;
    logic [7:0]  tb_addr;
    logic [31:0] tb_data;
    logic [31:0] mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  exp_rd_q [$];
    logic [39:0] exp_wr_q [$];

    int vals    [6] = '{-3, -1, 0, 5, 127, -128};
    int ref_out [6] = '{0, 0, 0, 5, 127, 0};

    always #5 clk = ~clk;

    relu_with_mem dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .done        (done),
        .input_addr  (input_addr),
        .output_addr (output_addr),
        .mem_w       (mem_w),
        .mem_sel     (mem_sel),
        .address_bus (address_bus),
        .data_bus    (data_bus)
`ifdef RELU_NEG_COUNT_EN
        ,
        .neg_count   (neg_count)
`endif
    );

    assign address_bus = tb_bus_en ? tb_addr : 8'bz;
    assign data_bus    = (mem_sel && !mem_w) ? mem[address_bus] :
                         (tb_bus_en ? tb_data : 32'bz);

    always @(posedge clk) begin
        if (mem_sel && mem_w) begin
            mem[address_bus] <= data_bus;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic        prev_rd = 1'b0;
    logic [39:0] wr_e;
    always @(negedge clk) begin
        if (mem_sel && !mem_w && !prev_rd) begin
            if (exp_rd_q.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_addr", {24'd0, address_bus}, {24'd0, exp_rd_q.pop_front()});
        end
        if (mem_sel && mem_w) begin
            if (exp_wr_q.size() == 0) begin
                chk("wr_unexpected", 1, 0);
            end else begin
                wr_e = exp_wr_q.pop_front();
                chk("wr_addr", {24'd0, address_bus}, {24'd0, wr_e[39:32]});
                chk("wr_data", data_bus, wr_e[31:0]);
            end
        end
        prev_rd = mem_sel && !mem_w;
    end

    task automatic load(input logic [7:0] base);
        logic [7:0] a;
        for (int k = 0; k < 6; k++) begin
            a = base + 8'(k);
            mem[a] = vals[k];
        end
    endtask

    task automatic run(input logic [7:0] ib, input logic [7:0] ob,
                       input bit mid_pulse, input int abort_at);
        logic [31:0] ey [6];
        logic [31:0] word;
        logic [7:0]  a;
        int          cycles;
`ifdef RELU_NEG_COUNT_EN
        int          negs = 0;
`endif
        for (int k = 0; k < 6; k++) begin
            a    = ib + 8'(k);
            word = mem[a];
            ey[k] = word[7] ? 32'd0 : {24'd0, word[7:0]};
`ifdef RELU_NEG_COUNT_EN
            if (word[7]) negs++;
`endif
            exp_rd_q.push_back(a);
            exp_wr_q.push_back({ob + 8'(k), ey[k]});
        end
        input_addr  = ib;
        output_addr = ob;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cycles = 1;
        while (!done && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (mid_pulse) begin
                start      = (cycles == 7);
                input_addr = (cycles == 7) ? 8'h80 : ib;
            end
            if (abort_at != 0 && cycles == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_done", {31'd0, done}, 0);
                chk("abort_sel", {31'd0, mem_sel}, 0);
                chk("abort_w", {31'd0, mem_w}, 0);
                exp_rd_q.delete();
                exp_wr_q.delete();
                return;
            end
        end
        chk("done_latency", cycles, 19);
        chk("wr_left", exp_wr_q.size(), 0);
        chk("rd_left", exp_rd_q.size(), 0);
        for (int k = 0; k < 6; k++) begin
            a = ob + 8'(k);
            chk("mem_result", mem[a], ey[k]);
        end
`ifdef RELU_NEG_COUNT_EN
        chk("neg_count", {24'd0, neg_count}, negs);
`endif
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        tb_bus_en   = 1'b0;
        tb_addr     = 8'd0;
        tb_data     = 32'd0;
        input_addr  = 8'd0;
        output_addr = 8'd0;
        for (int k = 0; k < 256; k++) mem[k] = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_sel", {31'd0, mem_sel}, 0);
        chk("rst_w", {31'd0, mem_w}, 0);
        rst = 1'b0;

        load(8'd0);
        run(8'd0, 8'd100, 1'b0, 0);
        for (int k = 0; k < 6; k++) chk("ref_table", mem[100 + k], ref_out[k]);
`ifdef RELU_NEG_COUNT_EN
        chk("neg_count_ref", {24'd0, neg_count}, 3);
`endif

        tb_bus_en = 1'b1;
        tb_addr   = 8'h5A;
        tb_data   = 32'hDEADBEEF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("bus_addr", {24'd0, address_bus}, 32'h5A);
            chk("bus_data", data_bus, 32'hDEADBEEF);
            chk("done_hold", {31'd0, done}, 1);
        end
        tb_bus_en = 1'b0;

        run(8'd0, 8'd0, 1'b0, 0);
        for (int k = 0; k < 6; k++) chk("inplace", mem[k], ref_out[k]);

        load(8'd0);
        run(8'd0, 8'd150, 1'b0, 10);
        tb_bus_en = 1'b1;
        tb_addr   = 8'hC3;
        tb_data   = 32'h12345678;
        @(negedge clk);
        chk("abort_bus_addr", {24'd0, address_bus}, 32'hC3);
        chk("abort_bus_data", data_bus, 32'h12345678);
        tb_bus_en = 1'b0;
        run(8'd0, 8'd150, 1'b0, 0);

        load(8'd254);
        run(8'd254, 8'd50, 1'b1, 0);
        for (int k = 0; k < 6; k++) chk("wrap", mem[50 + k], ref_out[k]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/relu_with_mem.md
RELU_WITH_MEM -- requirements
Module: relu_with_mem

Interface
REQ-001 Parameters: DATA_WIDTH, default 8, element width (signed two's complement).
REQ-002 Parameters: ADDR_WIDTH, default 8, memory word-address width.
REQ-003 Parameters: DATABUS_WIDTH, default 32, memory word / data bus width (>= DATA_WIDTH).
REQ-004 Parameters: HEIGHT, default 2, and WIDTH, default 3; element count N = HEIGHT*WIDTH, with 1 <= N <= 2^ADDR_WIDTH.
REQ-005 Port: clk  input  1  single clock; all logic on rising edge.
REQ-006 Port: rst  input  1  synchronous, active-high reset.
REQ-007 Port: start  input  1  begin operation when sampled high in IDLE or DONE.
REQ-008 Port: done  output  1  level, high while in DONE.
REQ-009 Port: input_addr  input  ADDR_WIDTH  base word address of N input elements.
REQ-010 Port: output_addr  input  ADDR_WIDTH  base word address of N result words.
REQ-011 Port: mem_w  output  1  memory write enable.
REQ-012 Port: mem_sel  output  1  memory select.
REQ-013 Port: address_bus  inout  ADDR_WIDTH  shared address bus; DUT drives it only while mem_sel=1, otherwise high-Z.
REQ-014 Port: data_bus  inout  DATABUS_WIDTH  shared data bus; DUT drives it only in WR, otherwise high-Z.

Function
REQ-015 States: IDLE, RD_ADDR, RD_WAIT, WR, DONE.
REQ-016 IDLE/DONE with start=1: latch input_addr and output_addr, clear index i to 0, go to RD_ADDR; start is ignored in all other states.
REQ-017 RD_ADDR and RD_WAIT: address_bus = in_base+i, mem_sel=1, mem_w=0; RD_ADDR -> RD_WAIT unconditionally.
REQ-018 At the end of RD_WAIT, capture data_bus[DATA_WIDTH-1:0] as signed x and go to WR; this tolerates combinational or 1-cycle registered memory read.
REQ-019 WR: address_bus = out_base+i, mem_sel=1, mem_w=1, data_bus = zero-extended y, where y = (x<0) ? 0 : x.
REQ-020 After WR: if i == N-1 go to DONE, else i <= i+1 and go to RD_ADDR.
REQ-021 Address arithmetic wraps modulo 2^ADDR_WIDTH.
REQ-022 Latency: done rises 3N+1 cycles after the cycle in which start is sampled; each element costs exactly 3 cycles.
REQ-023 In IDLE and DONE: mem_sel=0, mem_w=0, both buses high-Z.
REQ-024 Memory regions may overlap, including in-place (in_base == out_base); element i is read before it is written.

Reset
REQ-025 rst=1 at a clock edge forces IDLE, i=0, done=0, mem_sel=0, mem_w=0 and releases both buses, including mid-operation; a partially written output region is left as-is.

Configuration
REQ-026 With RELU_NEG_COUNT_EN defined, the module adds output neg_count [ADDR_WIDTH] holding the number of elements clamped (x<0) in the last run; it is cleared on start and reset and valid while done=1.
REQ-027 Without RELU_NEG_COUNT_EN, the neg_count port and its counter are absent and all other behaviour is identical.

Structure
REQ-028 Package relu_pkg holds the state enum type and the default width constants.
REQ-029 Sub-module relu_unit is a purely combinational DATA_WIDTH signed-in / DATABUS_WIDTH zero-extended-out clamp.

Verification
REQ-030 Memory [0..5] = -3, -1, 0, 5, 127, -128 (sign-extended), input_addr=0, output_addr=100, pulse start -> mem[100..105] = 0, 0, 0, 5, 127, 0; done high 19 cycles after start.
REQ-031 After done, the bench drives the buses and reads back -> no bus contention (no X on the buses) and done stays high until the next start.
REQ-032 In-place run with input_addr = output_addr = 0 on the same data -> mem[0..5] = 0, 0, 0, 5, 127, 0.
REQ-033 Assert rst during element 3 of a run, then restart -> DUT returns to IDLE with buses Z, and the second run completes correctly.
REQ-034 input_addr=254, N=6 -> reads from addresses 254, 255, 0, 1, 2, 3 (wrap); start pulsed mid-run has no effect.
REQ-035 With RELU_NEG_COUNT_EN defined, the REQ-030 data -> neg_count=3.
